// File: rtl/shift_arb_pkg.sv
// Shared types and widths for the shift arbiter and its datapath core.
// Build option SHIFT_ARB_SLL_EN adds the left-shift operation.
package shift_arb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SH_W   = 5;

   typedef enum logic [1:0] {
      OP_SRL = 2'd0,
      OP_SRA = 2'd1,
      OP_SLL = 2'd2
   } shift_op_e;

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: SRL/SRA, plus SLL when SHIFT_ARB_SLL_EN is defined.
// Without the macro no left shifter is built.
module shift_core
   import shift_arb_pkg::*;
(
   input  logic [DATA_W-1:0] tg_i,
   input  logic [SH_W-1:0]   sh_i,
   input  shift_op_e         op_i,
   output logic [DATA_W-1:0] res_o
);

   always_comb begin
      res_o = tg_i >> sh_i;
      case (op_i)
         OP_SRA:  res_o = $unsigned($signed(tg_i) >>> sh_i);
`ifdef SHIFT_ARB_SLL_EN
         OP_SLL:  res_o = tg_i << sh_i;
`endif
         default: res_o = tg_i >> sh_i;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin shared right-shift unit with a single registered, id-tagged response slot.
// Defining SHIFT_ARB_SLL_EN adds the req_left port and the SLL operation.
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_arith,
   input  logic [NREQ*DATA_W-1:0]   req_tg,
   input  logic [NREQ*SH_W-1:0]     req_sh,
`ifdef SHIFT_ARB_SLL_EN
   input  logic [NREQ-1:0]          req_left,
`endif
   output logic                     rsp_valid,
   output logic [IDW-1:0]           rsp_id,
   output logic [DATA_W-1:0]        rsp_res,
   input  logic                     rsp_ready
);

   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
   logic [IDW-1:0]    last_grant_q, last_grant_d;

   logic              grant_found;
   logic [IDW-1:0]    grant_id;
   logic [IDW-1:0]    cand;
   logic              slot_free;
   logic              accept;
   logic [DATA_W-1:0] sel_tg;
   logic [SH_W-1:0]   sel_sh;
   shift_op_e         sel_op;
   logic [DATA_W-1:0] core_res;

   // Rotating priority: scan starts just after the last granted requester.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = IDW'((32'(last_grant_q) + i) % NREQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   assign slot_free = !rsp_valid_q || rsp_ready;

   always_comb begin
      req_ready = '0;
      if (rst_n && grant_found && slot_free) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   assign accept = |req_ready;

   always_comb begin
      sel_tg = '0;
      sel_sh = '0;
      sel_op = OP_SRL;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_id == i[IDW-1:0]) begin
            sel_tg = req_tg[DATA_W*i +: DATA_W];
            sel_sh = req_sh[SH_W*i +: SH_W];
            sel_op = req_arith[i] ? OP_SRA : OP_SRL;
`ifdef SHIFT_ARB_SLL_EN
            if (req_left[i]) begin
               sel_op = OP_SLL;
            end
`endif
         end
      end
   end

   shift_core u_shift_core (
      .tg_i  (sel_tg),
      .sh_i  (sel_sh),
      .op_i  (sel_op),
      .res_o (core_res)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_res_d    = rsp_res_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant_id;
         rsp_res_d    = core_res;
         last_grant_d = grant_id;
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_res_q    <= '0;
         last_grant_q <= IDW'(NREQ - 1);
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_res_q    <= rsp_res_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_res   = rsp_res_q;

endmodule
